carry_skip_adder_pipe: RTL and testbench



---
 rtl/carry_skip_adder_pipe_pkg.sv | 28 ++
 rtl/carry_skip_adder_pipe_if.sv | 34 +++
 rtl/carry_skip_adder_pipe_csa_block.sv | 31 +++
 rtl/carry_skip_adder_pipe.sv | 92 +++++++++
 tb/tb_carry_skip_adder_pipe.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/carry_skip_adder_pipe_pkg.sv
// rtl/carry_skip_adder_pipe_pkg.sv - shared types and helpers for the carry-skip adder pipeline (CSA_OVERFLOW_EN adds sign bits)
package csa_pkg;

    // Widest operand the stage payload can carry; unused upper bits are pruned by synthesis.
    localparam int CSA_MAX_WIDTH = 64;

    typedef struct packed {
        logic                     valid;
        logic                     carry;
`ifdef CSA_OVERFLOW_EN
        logic                     sign_a;
        logic                     sign_b;
`endif
        logic [CSA_MAX_WIDTH-1:0] a_rem;
        logic [CSA_MAX_WIDTH-1:0] b_rem;
        logic [CSA_MAX_WIDTH-1:0] psum;
    } stage_t;

    function automatic int csa_nblk(input int width, input int block);
        return width / block;
    endfunction

    function automatic bit csa_cfg_ok(input int width, input int block);
        return (block > 0) && (width >= block) && ((width % block) == 0)
            && (width <= CSA_MAX_WIDTH);
    endfunction

endpackage

// File: rtl/carry_skip_adder_pipe_if.sv
// rtl/carry_skip_adder_pipe_if.sv - operand/result stream interface (CSA_OVERFLOW_EN adds ovf)
interface carry_skip_adder_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CSA_OVERFLOW_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
`ifdef CSA_OVERFLOW_EN
        input  ovf,
`endif
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
`ifdef CSA_OVERFLOW_EN
        output ovf,
`endif
        output in_ready, out_valid, sum, cout
    );

endinterface

// File: rtl/carry_skip_adder_pipe_csa_block.sv
// rtl/carry_skip_adder_pipe_csa_block.sv - one combinational ripple block with propagate-skip carry out
module csa_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             ci,
    output logic [BLOCK-1:0] s,
    output logic             co,
    output logic             p
);
    logic [BLOCK:0]   c;
    logic [BLOCK-1:0] prop_bits;

    assign prop_bits = a ^ b;

    // Ripple carry chain across the block; c[i] is the carry into bit i.
    always_comb begin
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < BLOCK; i++) begin
            c[i+1] = (a[i] & b[i]) | (prop_bits[i] & c[i]);
        end
    end

    assign s  = prop_bits ^ c[BLOCK-1:0];
    assign p  = &prop_bits;
    // When every bit propagates, the block carry-out equals its carry-in; skip the ripple.
    assign co = p ? ci : c[BLOCK];

endmodule

// File: rtl/carry_skip_adder_pipe.sv
// rtl/carry_skip_adder_pipe.sv - pipelined carry-skip adder, one block per stage (CSA_OVERFLOW_EN adds ovf)
module carry_skip_adder_pipe
    import csa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input logic                   clk,
    input logic                   rst,
    carry_skip_adder_pipe_if.slave bus
);
    localparam int NBLK = csa_nblk(WIDTH, BLOCK);
    localparam int LAST = NBLK - 1;

    if (!csa_cfg_ok(WIDTH, BLOCK)) begin : g_bad_cfg
        $error("carry_skip_adder_pipe: WIDTH must be a multiple of BLOCK, >= BLOCK and <= CSA_MAX_WIDTH");
    end

    logic            advance;
    logic [NBLK-1:0] prop;
    logic            unused_bits;

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        stage_t           src;
        stage_t           nxt;
        stage_t           r;
        logic [BLOCK-1:0] s;
        logic             co;

        if (k == 0) begin : g_first
            // Stage 0 takes its operands straight from the input stream.
            always_comb begin
                src                  = '0;
                src.valid            = bus.in_valid;
                src.carry            = bus.cin;
                src.a_rem[WIDTH-1:0] = bus.a;
                src.b_rem[WIDTH-1:0] = bus.b;
`ifdef CSA_OVERFLOW_EN
                src.sign_a           = bus.a[WIDTH-1];
                src.sign_b           = bus.b[WIDTH-1];
`endif
            end
        end else begin : g_rest
            assign src = g_stage[k-1].r;
        end

        csa_block #(
            .BLOCK(BLOCK)
        ) u_blk (
            .a (src.a_rem[BLOCK-1:0]),
            .b (src.b_rem[BLOCK-1:0]),
            .ci(src.carry),
            .s (s),
            .co(co),
            .p (prop[k])
        );

        // Consume the low operand block, shift the rest down, and deposit this block's sum bits.
        always_comb begin
            nxt                        = src;
            nxt.carry                  = co;
            nxt.a_rem                  = src.a_rem >> BLOCK;
            nxt.b_rem                  = src.b_rem >> BLOCK;
            nxt.psum[k*BLOCK +: BLOCK] = s;
        end

        // Stage register; holds (bubbles included) whenever the output is stalled.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r <= '0;
            end else if (advance) begin
                r <= nxt;
            end
        end
    end

    assign advance       = !g_stage[LAST].r.valid || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = g_stage[LAST].r.valid;
    assign bus.sum       = g_stage[LAST].r.psum[WIDTH-1:0];
    assign bus.cout      = g_stage[LAST].r.carry;

`ifdef CSA_OVERFLOW_EN
    assign bus.ovf = (g_stage[LAST].r.sign_a == g_stage[LAST].r.sign_b)
                  && (g_stage[LAST].r.psum[WIDTH-1] != g_stage[LAST].r.sign_a);
`endif

    // The last stage's operand remainders and the block propagate flags have no consumer.
    assign unused_bits = ^{g_stage[LAST].r.a_rem, g_stage[LAST].r.b_rem,
                           g_stage[LAST].r.psum, prop};

endmodule

// File: tb/tb_carry_skip_adder_pipe.sv
// tb/tb_carry_skip_adder_pipe.sv - scoreboard bench for carry_skip_adder_pipe (CSA_OVERFLOW_EN adds ovf test)
module tb_carry_skip_adder_pipe;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    carry_skip_adder_pipe_if #(.WIDTH(16)) bus16 ();
    carry_skip_adder_pipe_if #(.WIDTH(32)) bus32 ();
    carry_skip_adder_pipe_if #(.WIDTH(8))  bus8 ();

    carry_skip_adder_pipe #(.WIDTH(16), .BLOCK(4)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
    carry_skip_adder_pipe #(.WIDTH(32), .BLOCK(8)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
    carry_skip_adder_pipe #(.WIDTH(8),  .BLOCK(8)) u_dut8  (.clk(clk), .rst(rst), .bus(bus8));

    logic [16:0] q16 [$];
    logic [32:0] q32 [$];
    logic [8:0]  q8  [$];

    task automatic idle_all();
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.out_ready = 1'b1;
        bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.out_ready = 1'b1;
        bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0; bus8.out_ready  = 1'b1;
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus16.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid16 actual=%b expected=0", bus16.out_valid); end
        checks++; if (bus16.sum !== 16'h0000) begin failures++; $display("FAIL reset_sum16 actual=%h expected=0000", bus16.sum); end
        checks++; if (bus16.cout !== 1'b0) begin failures++; $display("FAIL reset_cout16 actual=%b expected=0", bus16.cout); end
        checks++; if (bus32.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid32 actual=%b expected=0", bus32.out_valid); end
        checks++; if (bus8.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid8 actual=%b expected=0", bus8.out_valid); end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus16.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready16 actual=%b expected=1", bus16.in_ready); end
        checks++; if (bus8.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready8 actual=%b expected=1", bus8.in_ready); end
    endtask

    task automatic test_latency();
        int lat;
        bus16.out_ready = 1'b1;
        bus16.in_valid  = 1'b1;
        bus16.a = 16'h1234; bus16.b = 16'h4321; bus16.cin = 1'b0;
        @(negedge clk);
        checks++; if (bus16.in_ready !== 1'b1) begin failures++; $display("FAIL lat_accept actual=%b expected=1", bus16.in_ready); end
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        lat = 1;
        while (bus16.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat != 4) begin failures++; $display("FAIL lat_cycles actual=%0d expected=4", lat); end
        checks++; if (bus16.sum !== 16'h5555) begin failures++; $display("FAIL lat_sum actual=%h expected=5555", bus16.sum); end
        checks++; if (bus16.cout !== 1'b0) begin failures++; $display("FAIL lat_cout actual=%b expected=0", bus16.cout); end
        @(posedge clk); #1;
    endtask

    task automatic test_skip_path();
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic        vc [3];
        logic [16:0] ve [3];
        logic [16:0] e;
        int sent = 0;
        int cyc  = 0;
        va[0] = 16'hFFFF; vb[0] = 16'h0000; vc[0] = 1'b1; ve[0] = 17'h10000;
        va[1] = 16'hAAAA; vb[1] = 16'h5555; vc[1] = 1'b1; ve[1] = 17'h10000;
        va[2] = 16'hF0F0; vb[2] = 16'h0F0F; vc[2] = 1'b0; ve[2] = 17'h0FFFF;
        bus16.out_ready = 1'b1;
        while ((sent < 3 || q16.size() > 0) && cyc < 40) begin
            if (sent < 3) begin
                bus16.in_valid = 1'b1; bus16.a = va[sent]; bus16.b = vb[sent]; bus16.cin = vc[sent];
            end else begin
                bus16.in_valid = 1'b0;
            end
            @(negedge clk);
            if (bus16.out_valid && bus16.out_ready) begin
                checks++;
                if (q16.size() == 0) begin
                    failures++; $display("FAIL skip_unexpected actual=%h expected=none", {bus16.cout, bus16.sum});
                end else begin
                    e = q16.pop_front();
                    if ({bus16.cout, bus16.sum} !== e) begin failures++; $display("FAIL skip_result actual=%h expected=%h", {bus16.cout, bus16.sum}, e); end
                end
            end
            if (bus16.in_valid && bus16.in_ready) begin q16.push_back(ve[sent]); sent++; end
            @(posedge clk); #1;
            cyc++;
        end
        bus16.in_valid = 1'b0;
        checks++; if (sent != 3 || q16.size() != 0) begin failures++; $display("FAIL skip_drain actual=%0d expected=3", sent); q16.delete(); end
    endtask

    task automatic test_back_to_back();
        logic [16:0] e;
        logic [16:0] held;
        int sent  = 0;
        int got   = 0;
        int cyc   = 0;
        int first = -1;
        bus16.out_ready = 1'b1;
        while ((sent < 8 || q16.size() > 0) && cyc < 60) begin
            if (sent < 8) begin
                bus16.in_valid = 1'b1; bus16.a = 16'($urandom); bus16.b = 16'($urandom); bus16.cin = 1'(sent & 1);
            end else begin
                bus16.in_valid = 1'b0;
            end
            @(negedge clk);
            if (sent < 8) begin
                checks++; if (bus16.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready actual=%b expected=1", bus16.in_ready); end
            end
            if (bus16.out_valid && bus16.out_ready) begin
                if (first < 0) first = cyc;
                checks++; if (cyc != first + got) begin failures++; $display("FAIL b2b_gap actual=%0d expected=%0d", cyc, first + got); end
                checks++;
                if (q16.size() == 0) begin
                    failures++; $display("FAIL b2b_unexpected actual=%h expected=none", {bus16.cout, bus16.sum});
                end else begin
                    e = q16.pop_front();
                    if ({bus16.cout, bus16.sum} !== e) begin failures++; $display("FAIL b2b_result actual=%h expected=%h", {bus16.cout, bus16.sum}, e); end
                end
                got++;
            end
            if (bus16.in_valid && bus16.in_ready) begin
                q16.push_back(17'(bus16.a) + 17'(bus16.b) + 17'(bus16.cin)); sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus16.in_valid = 1'b0;
        checks++; if (got != 8) begin failures++; $display("FAIL b2b_count actual=%0d expected=8", got); q16.delete(); end

        // Fill the pipe while the consumer is not ready, then hold it stalled.
        sent = 0; cyc = 0;
        bus16.out_ready = 1'b0;
        while (sent < 4 && cyc < 20) begin
            bus16.in_valid = 1'b1; bus16.a = 16'($urandom); bus16.b = 16'($urandom); bus16.cin = 1'b1;
            @(negedge clk);
            if (bus16.in_valid && bus16.in_ready) begin
                q16.push_back(17'(bus16.a) + 17'(bus16.b) + 17'(bus16.cin)); sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus16.in_valid = 1'b1; bus16.a = 16'hFFFF; bus16.b = 16'hFFFF; bus16.cin = 1'b1;
        held = {bus16.cout, bus16.sum};
        checks++; if (q16.size() == 0 || held !== q16[0]) begin failures++; $display("FAIL stall_head actual=%h expected=%h", held, (q16.size() > 0) ? q16[0] : 17'h0); end
        repeat (3) begin
            @(negedge clk);
            checks++; if (bus16.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready actual=%b expected=0", bus16.in_ready); end
            checks++; if (bus16.out_valid !== 1'b1) begin failures++; $display("FAIL stall_out_valid actual=%b expected=1", bus16.out_valid); end
            checks++; if ({bus16.cout, bus16.sum} !== held) begin failures++; $display("FAIL stall_stable actual=%h expected=%h", {bus16.cout, bus16.sum}, held); end
            @(posedge clk); #1;
        end
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        got = 0; cyc = 0;
        while (cyc < 12) begin
            @(negedge clk);
            if (bus16.out_valid && bus16.out_ready) begin
                checks++;
                if (q16.size() == 0) begin
                    failures++; $display("FAIL stall_duplicate actual=%h expected=none", {bus16.cout, bus16.sum});
                end else begin
                    e = q16.pop_front();
                    if ({bus16.cout, bus16.sum} !== e) begin failures++; $display("FAIL stall_result actual=%h expected=%h", {bus16.cout, bus16.sum}, e); end
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (got != 4) begin failures++; $display("FAIL stall_count actual=%0d expected=4", got); end
        q16.delete();
    endtask

    task automatic test_random16();
        logic [16:0] e;
        int n = 10000;
        int sent = 0;
        int cyc  = 0;
        while ((sent < n || q16.size() > 0) && cyc < 40000) begin
            bus16.out_ready = ($urandom_range(0, 3) != 0);
            if (sent < n && $urandom_range(0, 3) != 0) begin
                bus16.in_valid = 1'b1;
                bus16.a   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                bus16.b   = ($urandom_range(0, 3) == 0) ? ~bus16.a : 16'($urandom);
                bus16.cin = 1'($urandom_range(0, 1));
            end else begin
                bus16.in_valid = 1'b0;
            end
            @(negedge clk);
            if (bus16.out_valid && bus16.out_ready) begin
                checks++;
                if (q16.size() == 0) begin
                    failures++; $display("FAIL rnd16_unexpected actual=%h expected=none", {bus16.cout, bus16.sum});
                end else begin
                    e = q16.pop_front();
                    if ({bus16.cout, bus16.sum} !== e) begin failures++; $display("FAIL rnd16_result actual=%h expected=%h", {bus16.cout, bus16.sum}, e); end
                end
            end
            if (bus16.in_valid && bus16.in_ready) begin
                q16.push_back(17'(bus16.a) + 17'(bus16.b) + 17'(bus16.cin)); sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus16.in_valid = 1'b0; bus16.out_ready = 1'b1;
        checks++; if (sent != n || q16.size() != 0) begin failures++; $display("FAIL rnd16_timeout actual=%0d expected=%0d", sent, n); q16.delete(); end
    endtask

    task automatic test_random32();
        logic [32:0] e;
        int n = 4000;
        int sent = 0;
        int cyc  = 0;
        while ((sent < n || q32.size() > 0) && cyc < 20000) begin
            bus32.out_ready = ($urandom_range(0, 3) != 0);
            if (sent < n && $urandom_range(0, 3) != 0) begin
                bus32.in_valid = 1'b1;
                bus32.a   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
                bus32.b   = ($urandom_range(0, 3) == 0) ? ~bus32.a : 32'($urandom);
                bus32.cin = 1'($urandom_range(0, 1));
            end else begin
                bus32.in_valid = 1'b0;
            end
            @(negedge clk);
            if (bus32.out_valid && bus32.out_ready) begin
                checks++;
                if (q32.size() == 0) begin
                    failures++; $display("FAIL rnd32_unexpected actual=%h expected=none", {bus32.cout, bus32.sum});
                end else begin
                    e = q32.pop_front();
                    if ({bus32.cout, bus32.sum} !== e) begin failures++; $display("FAIL rnd32_result actual=%h expected=%h", {bus32.cout, bus32.sum}, e); end
                end
            end
            if (bus32.in_valid && bus32.in_ready) begin
                q32.push_back(33'(bus32.a) + 33'(bus32.b) + 33'(bus32.cin)); sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus32.in_valid = 1'b0; bus32.out_ready = 1'b1;
        checks++; if (sent != n || q32.size() != 0) begin failures++; $display("FAIL rnd32_timeout actual=%0d expected=%0d", sent, n); q32.delete(); end
    endtask

    task automatic test_random8();
        logic [8:0] e;
        int n = 4000;
        int sent = 0;
        int cyc  = 0;
        // Single-stage build: result must follow the accepting edge directly.
        bus8.out_ready = 1'b1;
        bus8.in_valid = 1'b1; bus8.a = 8'hFF; bus8.b = 8'h00; bus8.cin = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        checks++; if (bus8.out_valid !== 1'b1) begin failures++; $display("FAIL deg_latency actual=%b expected=1", bus8.out_valid); end
        checks++; if ({bus8.cout, bus8.sum} !== 9'h100) begin failures++; $display("FAIL deg_result actual=%h expected=100", {bus8.cout, bus8.sum}); end
        @(posedge clk); #1;
        while ((sent < n || q8.size() > 0) && cyc < 20000) begin
            bus8.out_ready = ($urandom_range(0, 3) != 0);
            if (sent < n && $urandom_range(0, 3) != 0) begin
                bus8.in_valid = 1'b1;
                bus8.a   = 8'($urandom);
                bus8.b   = ($urandom_range(0, 3) == 0) ? ~bus8.a : 8'($urandom);
                bus8.cin = 1'($urandom_range(0, 1));
            end else begin
                bus8.in_valid = 1'b0;
            end
            @(negedge clk);
            if (bus8.out_valid && bus8.out_ready) begin
                checks++;
                if (q8.size() == 0) begin
                    failures++; $display("FAIL rnd8_unexpected actual=%h expected=none", {bus8.cout, bus8.sum});
                end else begin
                    e = q8.pop_front();
                    if ({bus8.cout, bus8.sum} !== e) begin failures++; $display("FAIL rnd8_result actual=%h expected=%h", {bus8.cout, bus8.sum}, e); end
                end
            end
            if (bus8.in_valid && bus8.in_ready) begin
                q8.push_back(9'(bus8.a) + 9'(bus8.b) + 9'(bus8.cin)); sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;
        checks++; if (sent != n || q8.size() != 0) begin failures++; $display("FAIL rnd8_timeout actual=%0d expected=%0d", sent, n); q8.delete(); end
    endtask

    task automatic test_async_reset();
        logic [16:0] e;
        int sent = 0;
        int cyc  = 0;
        int got  = 0;
        bus16.out_ready = 1'b0;
        while (sent < 3 && cyc < 20) begin
            bus16.in_valid = 1'b1; bus16.a = 16'($urandom); bus16.b = 16'($urandom); bus16.cin = 1'b1;
            @(negedge clk);
            if (bus16.in_valid && bus16.in_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        bus16.in_valid = 1'b0;
        cyc = 0;
        while (bus16.out_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (bus16.out_valid !== 1'b1) begin failures++; $display("FAIL arst_preload actual=%b expected=1", bus16.out_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus16.out_valid !== 1'b0) begin failures++; $display("FAIL arst_out_valid actual=%b expected=0", bus16.out_valid); end
        checks++; if (bus16.sum !== 16'h0000) begin failures++; $display("FAIL arst_sum actual=%h expected=0000", bus16.sum); end
        checks++; if (bus16.cout !== 1'b0) begin failures++; $display("FAIL arst_cout actual=%b expected=0", bus16.cout); end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus16.in_ready !== 1'b1) begin failures++; $display("FAIL arst_in_ready actual=%b expected=1", bus16.in_ready); end
        q16.delete();
        bus16.out_ready = 1'b1;
        bus16.in_valid = 1'b1; bus16.a = 16'h0F0F; bus16.b = 16'h00F1; bus16.cin = 1'b1;
        cyc = 0;
        while (cyc < 12) begin
            @(negedge clk);
            if (bus16.out_valid && bus16.out_ready) begin
                checks++;
                if (q16.size() == 0) begin
                    failures++; $display("FAIL arst_stale actual=%h expected=none", {bus16.cout, bus16.sum});
                end else begin
                    e = q16.pop_front();
                    if ({bus16.cout, bus16.sum} !== e) begin failures++; $display("FAIL arst_result actual=%h expected=%h", {bus16.cout, bus16.sum}, e); end
                end
                got++;
            end
            if (bus16.in_valid && bus16.in_ready) q16.push_back(17'h01001);
            @(posedge clk); #1;
            bus16.in_valid = 1'b0;
            cyc++;
        end
        checks++; if (got != 1) begin failures++; $display("FAIL arst_count actual=%0d expected=1", got); end
        q16.delete();
    endtask

`ifdef CSA_OVERFLOW_EN
    task automatic test_overflow();
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic [17:0] ve [3];
        logic [17:0] e;
        logic [17:0] qo [$];
        int sent = 0;
        int cyc  = 0;
        va[0] = 16'h7FFF; vb[0] = 16'h0001; ve[0] = {1'b1, 1'b0, 16'h8000};
        va[1] = 16'h8000; vb[1] = 16'h8000; ve[1] = {1'b1, 1'b1, 16'h0000};
        va[2] = 16'h1234; vb[2] = 16'h4321; ve[2] = {1'b0, 1'b0, 16'h5555};
        bus16.out_ready = 1'b1;
        while ((sent < 3 || qo.size() > 0) && cyc < 40) begin
            if (sent < 3) begin
                bus16.in_valid = 1'b1; bus16.a = va[sent]; bus16.b = vb[sent]; bus16.cin = 1'b0;
            end else begin
                bus16.in_valid = 1'b0;
            end
            @(negedge clk);
            if (bus16.out_valid && bus16.out_ready) begin
                checks++;
                if (qo.size() == 0) begin
                    failures++; $display("FAIL ovf_unexpected actual=%h expected=none", {bus16.ovf, bus16.cout, bus16.sum});
                end else begin
                    e = qo.pop_front();
                    if ({bus16.ovf, bus16.cout, bus16.sum} !== e) begin failures++; $display("FAIL ovf_result actual=%h expected=%h", {bus16.ovf, bus16.cout, bus16.sum}, e); end
                end
            end
            if (bus16.in_valid && bus16.in_ready) begin qo.push_back(ve[sent]); sent++; end
            @(posedge clk); #1;
            cyc++;
        end
        bus16.in_valid = 1'b0;
        checks++; if (sent != 3 || qo.size() != 0) begin failures++; $display("FAIL ovf_drain actual=%0d expected=3", sent); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        idle_all();
        test_reset();
        test_latency();
        test_skip_path();
        test_back_to_back();
        test_random16();
        test_random32();
        test_random8();
        test_async_reset();
`ifdef CSA_OVERFLOW_EN
        test_overflow();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
